// File: rtl/reg_bank_16x64.sv
// rtl/reg_bank_16x64.sv - 16x64 register bank feeding the 16:1 read mux, with a sequential clear sweep
// Define REG16_BYTE_WRITE_EN to add the WrBe byte-enable port.
module reg_bank_16x64 #(
  parameter logic [63:0] RESET_VAL = 64'h0,
  parameter bit          ZERO_R0   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WrEn,
  input  logic [3:0]  WrAddr,
  input  logic [63:0] WrData,
`ifdef REG16_BYTE_WRITE_EN
  input  logic [7:0]  WrBe,
`endif
  input  logic        ClrReq,
  output logic        ClrBusy,
  output logic        ClrDone,
  output logic [63:0] Q0,
  output logic [63:0] Q1,
  output logic [63:0] Q2,
  output logic [63:0] Q3,
  output logic [63:0] Q4,
  output logic [63:0] Q5,
  output logic [63:0] Q6,
  output logic [63:0] Q7,
  output logic [63:0] Q8,
  output logic [63:0] Q9,
  output logic [63:0] Q10,
  output logic [63:0] Q11,
  output logic [63:0] Q12,
  output logic [63:0] Q13,
  output logic [63:0] Q14,
  output logic [63:0] Q15
);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [63:0] ent_q [16];
  logic [63:0] wmask_d;
  logic        wr_ok_d;

`ifdef REG16_BYTE_WRITE_EN
  always_comb begin
    wmask_d = '0;
    for (int b = 0; b < 8; b++) wmask_d[8*b +: 8] = {8{WrBe[b]}};
  end
`else
  always_comb wmask_d = '1;
`endif

  // Writes are dropped (not deferred) while the sweep owns the bank.
  always_comb wr_ok_d = WrEn && (state_q != CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (ClrReq) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) ent_q[i] <= (ZERO_R0 && i == 0) ? 64'h0 : RESET_VAL;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (ZERO_R0 && i == 0)
          ent_q[i] <= 64'h0;
        else if (state_q == CLEAR && cnt_q == 4'(i))
          ent_q[i] <= RESET_VAL;
        else if (wr_ok_d && WrAddr == 4'(i))
          ent_q[i] <= (ent_q[i] & ~wmask_d) | (WrData & wmask_d);
      end
    end
  end

  assign ClrBusy = busy_q;
  assign ClrDone = done_q;

  assign Q0  = ZERO_R0 ? 64'h0 : ent_q[0];
  assign Q1  = ent_q[1];
  assign Q2  = ent_q[2];
  assign Q3  = ent_q[3];
  assign Q4  = ent_q[4];
  assign Q5  = ent_q[5];
  assign Q6  = ent_q[6];
  assign Q7  = ent_q[7];
  assign Q8  = ent_q[8];
  assign Q9  = ent_q[9];
  assign Q10 = ent_q[10];
  assign Q11 = ent_q[11];
  assign Q12 = ent_q[12];
  assign Q13 = ent_q[13];
  assign Q14 = ent_q[14];
  assign Q15 = ent_q[15];

endmodule

// File: tb/tb_reg_bank_16x64.sv
// tb/tb_reg_bank_16x64.sv - bench for reg_bank_16x64, two instances (ZERO_R0=1 and ZERO_R0=0)
// Honours REG16_BYTE_WRITE_EN when defined.
module tb_reg_bank_16x64;

  localparam logic [63:0] RV1 = 64'h0;
  localparam logic [63:0] RV0 = 64'h0123_4567_89AB_CDEF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  addr = '0;
  logic [63:0] wd = '0;
  logic [63:0] q1 [16];
  logic [63:0] q0 [16];
  logic        busy1, done1, busy0, done0;
  int          total = 0;
  int          bad = 0;
  bit          chk = 1'b0;
  int          nb, nd;

`ifdef REG16_BYTE_WRITE_EN
  logic [7:0]  be = 8'hFF;
  wire  [7:0]  ebe = be;
`else
  wire  [7:0]  ebe = 8'hFF;
`endif

  always #5 clk = ~clk;

  reg_bank_16x64 #(.RESET_VAL(RV1), .ZERO_R0(1'b1)) dut (
    .clk(clk), .rst(rst), .WrEn(we), .WrAddr(addr), .WrData(wd),
`ifdef REG16_BYTE_WRITE_EN
    .WrBe(be),
`endif
    .ClrReq(clr), .ClrBusy(busy1), .ClrDone(done1),
    .Q0(q1[0]), .Q1(q1[1]), .Q2(q1[2]), .Q3(q1[3]), .Q4(q1[4]), .Q5(q1[5]),
    .Q6(q1[6]), .Q7(q1[7]), .Q8(q1[8]), .Q9(q1[9]), .Q10(q1[10]), .Q11(q1[11]),
    .Q12(q1[12]), .Q13(q1[13]), .Q14(q1[14]), .Q15(q1[15])
  );

  reg_bank_16x64 #(.RESET_VAL(RV0), .ZERO_R0(1'b0)) dut_nz (
    .clk(clk), .rst(rst), .WrEn(we), .WrAddr(addr), .WrData(wd),
`ifdef REG16_BYTE_WRITE_EN
    .WrBe(be),
`endif
    .ClrReq(clr), .ClrBusy(busy0), .ClrDone(done0),
    .Q0(q0[0]), .Q1(q0[1]), .Q2(q0[2]), .Q3(q0[3]), .Q4(q0[4]), .Q5(q0[5]),
    .Q6(q0[6]), .Q7(q0[7]), .Q8(q0[8]), .Q9(q0[9]), .Q10(q0[10]), .Q11(q0[11]),
    .Q12(q0[12]), .Q13(q0[13]), .Q14(q0[14]), .Q15(q0[15])
  );

  // Model: age = cycles since the edge that accepted ClrReq (0 = idle, 1..16 sweep, 17 done).
  int          age;
  logic [63:0] m1 [16];
  logic [63:0] m0 [16];

  function automatic logic [63:0] merge(logic [63:0] o, logic [63:0] n, logic [7:0] b);
    logic [63:0] r;
    r = o;
    for (int k = 0; k < 8; k++) if (b[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      age <= 0;
      for (int i = 0; i < 16; i++) begin
        m1[i] <= (i == 0) ? 64'h0 : RV1;
        m0[i] <= RV0;
      end
    end else begin
      if (we && (age == 0 || age == 17)) begin
        if (addr != 4'd0) m1[addr] <= merge(m1[addr], wd, ebe);
        m0[addr] <= merge(m0[addr], wd, ebe);
      end
      if (age >= 1 && age <= 16) begin
        if (age != 1) m1[age-1] <= RV1;
        m0[age-1] <= RV0;
      end
      if (age == 0) age <= clr ? 1 : 0;
      else if (age == 17) age <= 0;
      else age <= age + 1;
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      for (int i = 0; i < 16; i++) begin
        total++;
        if (q1[i] !== m1[i]) begin
          bad++;
          $display("FAIL z1_q%0d t=%0t got=%h exp=%h", i, $time, q1[i], m1[i]);
        end
        total++;
        if (q0[i] !== m0[i]) begin
          bad++;
          $display("FAIL z0_q%0d t=%0t got=%h exp=%h", i, $time, q0[i], m0[i]);
        end
      end
      total++;
      if (busy1 !== (age >= 1 && age <= 16) || busy0 !== busy1) begin
        bad++;
        $display("FAIL busy t=%0t got=%b/%b exp=%b", $time, busy1, busy0, (age >= 1 && age <= 16));
      end
      total++;
      if (done1 !== (age == 17) || done0 !== done1) begin
        bad++;
        $display("FAIL done t=%0t got=%b/%b exp=%b", $time, done1, done0, (age == 17));
      end
    end
  end

  task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [3:0] a, input logic [63:0] d, input logic c);
    we = w; addr = a; wd = d; clr = c;
    @(negedge clk);
    #1;
  endtask

`ifdef REG16_BYTE_WRITE_EN
  task automatic wrb(input logic [3:0] a, input logic [63:0] d, input logic [7:0] b);
    be = b;
    cyc(1'b1, a, d, 1'b0);
    be = 8'hFF;
  endtask
`endif

  initial begin
    #1 rst = 1'b1;
    chk = 1'b1;
    @(negedge clk);
    #1;
    lit("rst_q0_z1", q1[0], 64'h0);
    lit("rst_q9_z1", q1[9], 64'h0);
    lit("rst_q0_z0", q0[0], 64'h0123_4567_89AB_CDEF);
    lit("rst_busy", {63'h0, busy1}, 64'h0);
    rst = 1'b0;

    cyc(1'b1, 4'd5, 64'hDEADBEEF_00000001, 1'b0);
    lit("wr5_z1", q1[5], 64'hDEADBEEF_00000001);
    lit("wr5_q4", q1[4], 64'h0);
    lit("wr5_z0", q0[5], 64'hDEADBEEF_00000001);

    cyc(1'b1, 4'd0, 64'h1, 1'b0);
    lit("wr0_z1", q1[0], 64'h0);
    lit("wr0_z0", q0[0], 64'h1);

    for (int i = 0; i < 16; i++) cyc(1'b1, 4'(i), '1, 1'b0);
    lit("fill_q15", q1[15], 64'hFFFF_FFFF_FFFF_FFFF);

    // Full sweep with a dropped write and an ignored second ClrReq.
    cyc(1'b0, 4'd0, 64'h0, 1'b1);
    nb = 0; nd = 0;
    for (int i = 0; i < 24; i++) begin
      nb += int'(busy1);
      nd += int'(done1);
      if (i == 3) begin
        lit("order_q2", q1[2], 64'h0);
        lit("order_q3", q1[3], 64'hFFFF_FFFF_FFFF_FFFF);
      end
      if (i == 2) cyc(1'b1, 4'd3, 64'hAA, 1'b0);
      else if (i == 7) cyc(1'b0, 4'd0, 64'h0, 1'b1);
      else cyc(1'b0, 4'd0, 64'h0, 1'b0);
    end
    lit("busy_cycles", 64'(nb), 64'd16);
    lit("done_pulses", 64'(nd), 64'd1);
    lit("drop_q3_z1", q1[3], 64'h0);
    lit("drop_q3_z0", q0[3], 64'h0123_4567_89AB_CDEF);

    // Write together with ClrReq, then a write accepted in DONE.
    cyc(1'b1, 4'd9, 64'h5A5A, 1'b1);
    lit("wrclr_q9", q1[9], 64'h5A5A);
    for (int i = 0; i < 20; i++) begin
      if (i == 16) begin
        lit("done_c17", {63'h0, done1}, 64'h1);
        cyc(1'b1, 4'd12, 64'hC3, 1'b0);
      end else cyc(1'b0, 4'd0, 64'h0, 1'b0);
    end
    lit("wrclr_q9_end", q1[9], 64'h0);
    lit("wrdone_q12", q1[12], 64'hC3);

    // Reset during sweep cycle 7.
    cyc(1'b0, 4'd0, 64'h0, 1'b1);
    repeat (6) cyc(1'b0, 4'd0, 64'h0, 1'b0);
    rst = 1'b1;
    #2;
    lit("rstmid_busy", {63'h0, busy1}, 64'h0);
    lit("rstmid_q12_z1", q1[12], 64'h0);
    lit("rstmid_q12_z0", q0[12], 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    #1;
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      nd += int'(done1 | done0);
      cyc(1'b0, 4'd0, 64'h0, 1'b0);
    end
    lit("rstmid_nodone", 64'(nd), 64'd0);

`ifdef REG16_BYTE_WRITE_EN
    wrb(4'd2, 64'h0, 8'hFF);
    wrb(4'd2, 64'h1122334455667788, 8'h0F);
    lit("be_q2_z1", q1[2], 64'h0000000055667788);
    lit("be_q2_z0", q0[2], 64'h0000000055667788);
    wrb(4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    lit("be_zero_q2", q1[2], 64'h0000000055667788);
`endif

    cyc(1'b0, 4'd0, 64'h0, 1'b0);
    chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
